lsu_mem_port: RTL

Load/store initiator in the MEM stage of the pipelined RV32 core. Accepts one load or store per handshake from the pipeline, drives the data-memory port (`enable`/`write_read`/`mem_ctrl`/`addr`/`data_in`), waits for `read_done`, and captures `mem_error`. Returns extended load data or a fault code. It is the requesting end of the data-memory interface; the memory array answers it.

---
 rtl/lsu_mem_port.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator: one request per handshake, drives the data-memory port,
// returns extended load data or a fault code. Optional LSU_SPLIT_EN splits misaligned half/word into byte accesses.
module lsu_mem_port #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_ctrl,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [1:0]      resp_fault,
    output logic            mem_enable,
    output logic            mem_write_read,
    output logic [2:0]      mem_ctrl,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_read_done,
    input  logic            mem_error,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
`ifdef LSU_SPLIT_EN
    localparam logic [1:0] FIN    = 2'd3;
`endif

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_BUS     = 2'b01;
    localparam logic [1:0] F_ALIGN   = 2'b10;
    localparam logic [1:0] F_TIMEOUT = 2'b11;

    logic [1:0]      state;
    logic            we_q;
    logic [2:0]      ctrl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [CW-1:0]   wait_cnt;
    logic            in_access;
    logic            misalign;
    logic            reject;

`ifdef LSU_SPLIT_EN
    logic            split_q;
    logic [1:0]      bidx;
    logic [1:0]      last_idx;
    logic [XLEN-1:0] acc;
    assign last_idx = (ctrl_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
`endif

    always_comb begin
        misalign = 1'b0;
        case (req_ctrl[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
`ifdef LSU_SPLIT_EN
        reject = &req_ctrl[1:0];
`else
        reject = (&req_ctrl[1:0]) | misalign;
`endif
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign in_access  = (state == ACCESS);

    // Memory port is driven only while in ACCESS; everything else sees zeros.
    assign mem_enable     = in_access;
    assign mem_write_read = in_access & we_q;
`ifdef LSU_SPLIT_EN
    assign mem_ctrl  = !in_access ? 3'b000 : (split_q ? 3'b100 : ctrl_q);
    assign mem_addr  = !in_access ? '0 : (split_q ? addr_q + XLEN'(bidx) : addr_q);
    assign mem_wdata = !in_access ? '0 :
                       (split_q ? {{(XLEN-8){1'b0}}, wdata_q[{bidx, 3'b000} +: 8]} : wdata_q);
`else
    assign mem_ctrl  = in_access ? ctrl_q : 3'b000;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            ctrl_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            resp_data  <= '0;
            resp_fault <= F_OK;
`ifdef LSU_SPLIT_EN
            split_q    <= 1'b0;
            bidx       <= 2'd0;
            acc        <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    ctrl_q   <= req_ctrl;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    wait_cnt <= '0;
`ifdef LSU_SPLIT_EN
                    split_q  <= misalign;
                    bidx     <= 2'd0;
                    acc      <= '0;
`endif
                    if (reject) begin
                        resp_fault <= F_ALIGN;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Error beats done when both arrive in the same cycle.
                    if (mem_error) begin
                        resp_fault <= F_BUS;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else if (we_q || mem_read_done) begin
`ifdef LSU_SPLIT_EN
                        if (split_q) begin
                            if (!we_q) acc[{bidx, 3'b000} +: 8] <= mem_rdata[7:0];
                            wait_cnt <= '0;
                            if (bidx == last_idx) state <= FIN;
                            else bidx <= bidx + 2'd1;
                        end else
`endif
                        begin
                            resp_fault <= F_OK;
                            resp_data  <= we_q ? '0 : mem_rdata;
                            state      <= RESP;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        resp_fault <= F_TIMEOUT;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
`ifdef LSU_SPLIT_EN
                FIN: begin
                    resp_fault <= F_OK;
                    if (we_q)
                        resp_data <= '0;
                    else if (ctrl_q[1:0] == 2'b01)
                        resp_data <= ctrl_q[2] ? {{(XLEN-16){1'b0}}, acc[15:0]}
                                               : {{(XLEN-16){acc[15]}}, acc[15:0]};
                    else
                        resp_data <= acc;
                    state <= RESP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
